// File: rtl/mem_exception_unit.sv
// -----------------------------------------------------------------------------
// mem_exception_unit
//
// MEM-stage exception collector. It registers the exception flags produced in
// EXE (trap result included), detects misaligned data accesses and resolves
// MIPS32 exception priority. Each exception or ERET produces one CP0 write
// pulse and one pipeline flush. The PC redirect is then held on a valid/ready
// handshake until IF accepts it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   MEM_Stall_i-style inputs are named after the pipeline signals they carry:
//   MEM_Stall                freeze the MEM register
//   EXE_*                    instruction and exception flags from EXE
//   CP0_IntPending           unmasked interrupt pending
//   CP0_StatusBEV            boot exception vector select
//   CP0_EPC                  current EPC (ERET target)
//   IF_RedirectReady         IF accepts the redirect
//   MEM_Valid                MEM instruction valid and not excepting
//   MEM_Flush                one-cycle flush of IF/ID/EXE
//   Exc_We/Code/EPC/BD       CP0 exception write and its Cause/EPC payload
//   Exc_BadVAddrWe/BadVAddr  BadVAddr update for address errors
//   Eret_We                  one-cycle clear of Status.EXL
//   Redirect_Valid/PC        redirect request to IF
//
// State table
//   state      | meaning
//   RUN        | normal operation, exceptions and ERET may be taken
//   WAIT_RDR   | redirect pending, waiting for IF_RedirectReady
// -----------------------------------------------------------------------------
module mem_exception_unit #(
    parameter logic [31:0] EXC_VEC_BEV    = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VEC_NORMAL = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Stall,
    input  logic        EXE_Valid,
    input  logic [31:0] EXE_PC,
    input  logic        EXE_InDelaySlot,
    input  logic        EXE_ExcFetchAdEL,
    input  logic        EXE_ExcRI,
    input  logic        EXE_ExcOv,
    input  logic        EXE_TrapValid,
    input  logic        EXE_ExcSys,
    input  logic        EXE_ExcBp,
    input  logic        EXE_IsEret,
    input  logic        EXE_MemRead,
    input  logic        EXE_MemWrite,
    input  logic [1:0]  EXE_MemSize,
    input  logic [31:0] EXE_MemAddr,
    input  logic        CP0_IntPending,
    input  logic        CP0_StatusBEV,
    input  logic [31:0] CP0_EPC,
    input  logic        IF_RedirectReady,
    output logic        MEM_Valid,
    output logic        MEM_Flush,
    output logic        Exc_We,
    output logic [4:0]  Exc_Code,
    output logic [31:0] Exc_EPC,
    output logic        Exc_BD,
    output logic        Exc_BadVAddrWe,
    output logic [31:0] Exc_BadVAddr,
    output logic        Eret_We,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC
);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_WAIT_RDR = 1'b1
    } state_t;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0A;
    localparam logic [4:0] CODE_OV   = 5'h0C;
    localparam logic [4:0] CODE_TR   = 5'h0D;

    state_t state_q, state_d;

    // MEM pipeline register
    logic        valid_q;
    logic [31:0] pc_q;
    logic        bd_q;
    logic        fetch_adel_q, ri_q, ov_q, tr_q, sys_q, bp_q, eret_q;
    logic        rd_q, wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;

    // registered outputs
    logic        flush_q, exc_we_q, eret_we_q, bva_we_q, exc_bd_q, rdr_valid_q;
    logic [4:0]  exc_code_q;
    logic [31:0] exc_epc_q, bva_q, rdr_pc_q;

    logic        misal, dadel, dades;
    logic        exc_any;
    logic [4:0]  code_sel;
    logic        bva_we_sel;
    logic [31:0] bva_sel;
    logic        exc_take, eret_take;
    logic        valid_d;

    assign misal = ((size_q == 2'd1) & addr_q[0]) |
                   ((size_q == 2'd2) & (addr_q[1:0] != 2'b00));
    assign dadel = rd_q & misal;
    assign dades = wr_q & misal;

    assign exc_any = valid_q & (CP0_IntPending | fetch_adel_q | ri_q | ov_q |
                                tr_q | sys_q | bp_q | dadel | dades);

    // Priority encoder; only meaningful while exc_any is set.
    always_comb begin
        code_sel   = CODE_INT;
        bva_we_sel = 1'b0;
        bva_sel    = 32'h0;
        if (CP0_IntPending) begin
            code_sel = CODE_INT;
        end else if (fetch_adel_q) begin
            code_sel   = CODE_ADEL;
            bva_we_sel = 1'b1;
            bva_sel    = pc_q;
        end else if (ri_q) begin
            code_sel = CODE_RI;
        end else if (ov_q) begin
            code_sel = CODE_OV;
        end else if (tr_q) begin
            code_sel = CODE_TR;
        end else if (sys_q) begin
            code_sel = CODE_SYS;
        end else if (bp_q) begin
            code_sel = CODE_BP;
        end else if (dadel) begin
            code_sel   = CODE_ADEL;
            bva_we_sel = 1'b1;
            bva_sel    = addr_q;
        end else if (dades) begin
            code_sel   = CODE_ADES;
            bva_we_sel = 1'b1;
            bva_sel    = addr_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        exc_take  = 1'b0;
        eret_take = 1'b0;
        case (state_q)
            S_RUN: begin
                if (!MEM_Stall) begin
                    exc_take  = exc_any;
                    eret_take = valid_q & eret_q & ~exc_any;
                    if (exc_take || eret_take) begin
                        state_d = S_WAIT_RDR;
                    end
                end
            end
            S_WAIT_RDR: begin
                if (rdr_valid_q && IF_RedirectReady) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // The instruction entering MEM on a take edge is younger than the one
    // being redirected, so it must not be captured as valid.
    assign valid_d = EXE_Valid & (state_q == S_RUN) & ~flush_q &
                     ~exc_take & ~eret_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= 32'h0;
            bd_q         <= 1'b0;
            fetch_adel_q <= 1'b0;
            ri_q         <= 1'b0;
            ov_q         <= 1'b0;
            tr_q         <= 1'b0;
            sys_q        <= 1'b0;
            bp_q         <= 1'b0;
            eret_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'h0;
        end else if (!MEM_Stall) begin
            valid_q      <= valid_d;
            pc_q         <= EXE_PC;
            bd_q         <= EXE_InDelaySlot;
            fetch_adel_q <= EXE_ExcFetchAdEL;
            ri_q         <= EXE_ExcRI;
            ov_q         <= EXE_ExcOv;
            tr_q         <= EXE_TrapValid;
            sys_q        <= EXE_ExcSys;
            bp_q         <= EXE_ExcBp;
            eret_q       <= EXE_IsEret;
            rd_q         <= EXE_MemRead;
            wr_q         <= EXE_MemWrite;
            size_q       <= EXE_MemSize;
            addr_q       <= EXE_MemAddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q     <= 1'b0;
            exc_we_q    <= 1'b0;
            eret_we_q   <= 1'b0;
            bva_we_q    <= 1'b0;
            exc_code_q  <= 5'h0;
            exc_epc_q   <= 32'h0;
            exc_bd_q    <= 1'b0;
            bva_q       <= 32'h0;
            rdr_valid_q <= 1'b0;
            rdr_pc_q    <= 32'h0;
        end else begin
            flush_q   <= exc_take | eret_take;
            exc_we_q  <= exc_take;
            eret_we_q <= eret_take;
            bva_we_q  <= exc_take & bva_we_sel;
            if (exc_take) begin
                exc_code_q <= code_sel;
                exc_epc_q  <= bd_q ? (pc_q - 32'd4) : pc_q;
                exc_bd_q   <= bd_q;
                bva_q      <= bva_sel;
                rdr_pc_q   <= CP0_StatusBEV ? EXC_VEC_BEV : EXC_VEC_NORMAL;
            end else if (eret_take) begin
                rdr_pc_q <= CP0_EPC;
            end
            if (exc_take || eret_take) begin
                rdr_valid_q <= 1'b1;
            end else if (rdr_valid_q && IF_RedirectReady) begin
                rdr_valid_q <= 1'b0;
            end
        end
    end

    assign MEM_Valid      = valid_q & ~exc_any & ~eret_q;
    assign MEM_Flush      = flush_q;
    assign Exc_We         = exc_we_q;
    assign Exc_Code       = exc_code_q;
    assign Exc_EPC        = exc_epc_q;
    assign Exc_BD         = exc_bd_q;
    assign Exc_BadVAddrWe = bva_we_q;
    assign Exc_BadVAddr   = bva_q;
    assign Eret_We        = eret_we_q;
    assign Redirect_Valid = rdr_valid_q;
    assign Redirect_PC    = rdr_pc_q;

endmodule

// File: tb/tb_mem_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_exception_unit
//
// Directed bench for mem_exception_unit. Expected CP0/ERET writes are queued
// when an instruction is driven and compared when the DUT pulses Exc_We or
// Eret_We; cycle-level behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_mem_exception_unit;

    logic        clk;
    logic        rst;
    logic        MEM_Stall;
    logic        EXE_Valid;
    logic [31:0] EXE_PC;
    logic        EXE_InDelaySlot;
    logic        EXE_ExcFetchAdEL;
    logic        EXE_ExcRI;
    logic        EXE_ExcOv;
    logic        EXE_TrapValid;
    logic        EXE_ExcSys;
    logic        EXE_ExcBp;
    logic        EXE_IsEret;
    logic        EXE_MemRead;
    logic        EXE_MemWrite;
    logic [1:0]  EXE_MemSize;
    logic [31:0] EXE_MemAddr;
    logic        CP0_IntPending;
    logic        CP0_StatusBEV;
    logic [31:0] CP0_EPC;
    logic        IF_RedirectReady;
    logic        MEM_Valid;
    logic        MEM_Flush;
    logic        Exc_We;
    logic [4:0]  Exc_Code;
    logic [31:0] Exc_EPC;
    logic        Exc_BD;
    logic        Exc_BadVAddrWe;
    logic [31:0] Exc_BadVAddr;
    logic        Eret_We;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;

    mem_exception_unit dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_Stall        (MEM_Stall),
        .EXE_Valid        (EXE_Valid),
        .EXE_PC           (EXE_PC),
        .EXE_InDelaySlot  (EXE_InDelaySlot),
        .EXE_ExcFetchAdEL (EXE_ExcFetchAdEL),
        .EXE_ExcRI        (EXE_ExcRI),
        .EXE_ExcOv        (EXE_ExcOv),
        .EXE_TrapValid    (EXE_TrapValid),
        .EXE_ExcSys       (EXE_ExcSys),
        .EXE_ExcBp        (EXE_ExcBp),
        .EXE_IsEret       (EXE_IsEret),
        .EXE_MemRead      (EXE_MemRead),
        .EXE_MemWrite     (EXE_MemWrite),
        .EXE_MemSize      (EXE_MemSize),
        .EXE_MemAddr      (EXE_MemAddr),
        .CP0_IntPending   (CP0_IntPending),
        .CP0_StatusBEV    (CP0_StatusBEV),
        .CP0_EPC          (CP0_EPC),
        .IF_RedirectReady (IF_RedirectReady),
        .MEM_Valid        (MEM_Valid),
        .MEM_Flush        (MEM_Flush),
        .Exc_We           (Exc_We),
        .Exc_Code         (Exc_Code),
        .Exc_EPC          (Exc_EPC),
        .Exc_BD           (Exc_BD),
        .Exc_BadVAddrWe   (Exc_BadVAddrWe),
        .Exc_BadVAddr     (Exc_BadVAddr),
        .Eret_We          (Eret_We),
        .Redirect_Valid   (Redirect_Valid),
        .Redirect_PC      (Redirect_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_eret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        bvwe;
        logic [31:0] bva;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic eret, input logic [4:0] code,
                                input logic [31:0] epc, input logic bd,
                                input logic bvwe, input logic [31:0] bva,
                                input logic [31:0] rpc);
        exp_t e;
        e.is_eret = eret;
        e.code    = code;
        e.epc     = epc;
        e.bd      = bd;
        e.bvwe    = bvwe;
        e.bva     = bva;
        e.rpc     = rpc;
        return e;
    endfunction

    // Scoreboard consumer: every CP0/ERET write pulse must match the oldest
    // queued expectation.
    always @(negedge clk) begin
        if (!rst && (Exc_We || Eret_We)) begin
            chk("sb_event_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_exc_we",  32'(Exc_We),  32'(!e.is_eret));
                chk("sb_eret_we", 32'(Eret_We), 32'(e.is_eret));
                chk("sb_flush",   32'(MEM_Flush), 32'd1);
                chk("sb_rdr_pc",  Redirect_PC, e.rpc);
                if (!e.is_eret) begin
                    chk("sb_code", 32'(Exc_Code), 32'(e.code));
                    chk("sb_epc",  Exc_EPC, e.epc);
                    chk("sb_bd",   32'(Exc_BD), 32'(e.bd));
                    chk("sb_bvwe", 32'(Exc_BadVAddrWe), 32'(e.bvwe));
                    if (e.bvwe) chk("sb_bva", Exc_BadVAddr, e.bva);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_exe();
        EXE_Valid        = 1'b0;
        EXE_PC           = 32'h0;
        EXE_InDelaySlot  = 1'b0;
        EXE_ExcFetchAdEL = 1'b0;
        EXE_ExcRI        = 1'b0;
        EXE_ExcOv        = 1'b0;
        EXE_TrapValid    = 1'b0;
        EXE_ExcSys       = 1'b0;
        EXE_ExcBp        = 1'b0;
        EXE_IsEret       = 1'b0;
        EXE_MemRead      = 1'b0;
        EXE_MemWrite     = 1'b0;
        EXE_MemSize      = 2'd0;
        EXE_MemAddr      = 32'h0;
    endtask

    task automatic redirect(input string tag, input logic [31:0] rpc);
        chk({tag, "_rdr_valid"}, 32'(Redirect_Valid), 32'd1);
        chk({tag, "_rdr_pc"}, Redirect_PC, rpc);
        IF_RedirectReady = 1'b1;
        tick();
        IF_RedirectReady = 1'b0;
        chk({tag, "_rdr_drop"}, 32'(Redirect_Valid), 32'd0);
    endtask

    // EXE fields already driven: queue expectation, let it reach MEM, then
    // take the redirect.
    task automatic exc_case(input string tag, input exp_t e);
        sb_q.push_back(e);
        tick();
        chk({tag, "_memvalid"}, 32'(MEM_Valid), 32'd0);
        clr_exe();
        tick();
        chk({tag, "_flush"}, 32'(MEM_Flush), 32'd1);
        redirect(tag, e.rpc);
    endtask

    task automatic no_exc_case(input string tag);
        tick();
        chk({tag, "_memvalid"}, 32'(MEM_Valid), 32'd1);
        clr_exe();
        tick();
        chk({tag, "_no_we"}, 32'(Exc_We), 32'd0);
        chk({tag, "_no_flush"}, 32'(MEM_Flush), 32'd0);
        chk({tag, "_no_rdr"}, 32'(Redirect_Valid), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        MEM_Stall        = 1'b0;
        CP0_IntPending   = 1'b0;
        CP0_StatusBEV    = 1'b0;
        CP0_EPC          = 32'h0;
        IF_RedirectReady = 1'b0;
        clr_exe();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exc_we", 32'(Exc_We), 32'd0);
        chk("rst_flush", 32'(MEM_Flush), 32'd0);
        chk("rst_rdr_valid", 32'(Redirect_Valid), 32'd0);
        chk("rst_rdr_pc", Redirect_PC, 32'h0);
        chk("rst_mem_valid", 32'(MEM_Valid), 32'd0);
        rst = 1'b0;
        tick();

        // Trap with BEV=1, then handshake held off for 3 cycles while a
        // trap instruction passes through EXE.
        CP0_StatusBEV = 1'b1;
        EXE_Valid = 1'b1; EXE_PC = 32'hBFC0_0100; EXE_TrapValid = 1'b1;
        sb_q.push_back(mk(1'b0, 5'h0D, 32'hBFC0_0100, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380));
        tick();
        chk("trap_memvalid", 32'(MEM_Valid), 32'd0);
        chk("trap_not_early", 32'(Exc_We), 32'd0);
        clr_exe();
        tick();
        chk("trap_flush", 32'(MEM_Flush), 32'd1);
        chk("trap_rdr_valid", 32'(Redirect_Valid), 32'd1);
        EXE_Valid = 1'b1; EXE_PC = 32'hBFC0_0200; EXE_TrapValid = 1'b1;
        tick();
        clr_exe();
        chk("trap_flush_1cyc", 32'(MEM_Flush), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("hs_valid_held", 32'(Redirect_Valid), 32'd1);
            chk("hs_pc_stable", Redirect_PC, 32'hBFC0_0380);
            chk("hs_no_second_we", 32'(Exc_We), 32'd0);
            chk("hs_mem_invalid", 32'(MEM_Valid), 32'd0);
            tick();
        end
        redirect("trap", 32'hBFC0_0380);

        // Delay slot, Ov beats Tr, BEV=0.
        CP0_StatusBEV = 1'b0;
        EXE_Valid = 1'b1; EXE_PC = 32'h8000_0004; EXE_InDelaySlot = 1'b1;
        EXE_ExcOv = 1'b1; EXE_TrapValid = 1'b1;
        exc_case("ov_bd", mk(1'b0, 5'h0C, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 32'h8000_0180));

        // Misaligned word store.
        EXE_Valid = 1'b1; EXE_PC = 32'h0040_0000; EXE_MemWrite = 1'b1;
        EXE_MemSize = 2'd2; EXE_MemAddr = 32'h0000_1002;
        exc_case("ades", mk(1'b0, 5'h05, 32'h0040_0000, 1'b0, 1'b1, 32'h0000_1002, 32'h8000_0180));

        // Same address as a byte store: legal.
        EXE_Valid = 1'b1; EXE_PC = 32'h0040_0004; EXE_MemWrite = 1'b1;
        EXE_MemSize = 2'd0; EXE_MemAddr = 32'h0000_1002;
        no_exc_case("sb_ok");

        // Odd halfword load.
        EXE_Valid = 1'b1; EXE_PC = 32'h0040_0010; EXE_MemRead = 1'b1;
        EXE_MemSize = 2'd1; EXE_MemAddr = 32'h0000_2001;
        exc_case("adel_h", mk(1'b0, 5'h04, 32'h0040_0010, 1'b0, 1'b1, 32'h0000_2001, 32'h8000_0180));

        // Even halfword load: legal.
        EXE_Valid = 1'b1; EXE_PC = 32'h0040_0014; EXE_MemRead = 1'b1;
        EXE_MemSize = 2'd1; EXE_MemAddr = 32'h0000_2002;
        no_exc_case("lh_ok");

        // Fetch AdEL beats RI; BadVAddr is the PC.
        EXE_Valid = 1'b1; EXE_PC = 32'h0040_0003; EXE_ExcFetchAdEL = 1'b1; EXE_ExcRI = 1'b1;
        exc_case("fetch_adel", mk(1'b0, 5'h04, 32'h0040_0003, 1'b0, 1'b1, 32'h0040_0003, 32'h8000_0180));

        // ERET alone.
        CP0_EPC = 32'h8000_2000;
        EXE_Valid = 1'b1; EXE_PC = 32'h8000_0300; EXE_IsEret = 1'b1;
        exc_case("eret", mk(1'b1, 5'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h8000_2000));

        // Syscall beats ERET.
        EXE_Valid = 1'b1; EXE_PC = 32'h8000_0310; EXE_IsEret = 1'b1; EXE_ExcSys = 1'b1;
        exc_case("sys_eret", mk(1'b0, 5'h08, 32'h8000_0310, 1'b0, 1'b0, 32'h0, 32'h8000_0180));

        // Interrupt with empty MEM is not taken; taken on next valid insn.
        CP0_IntPending = 1'b1;
        tick();
        tick();
        chk("int_empty_no_we", 32'(Exc_We), 32'd0);
        chk("int_empty_no_rdr", 32'(Redirect_Valid), 32'd0);
        EXE_Valid = 1'b1; EXE_PC = 32'h0040_0020; EXE_ExcRI = 1'b1;
        exc_case("int", mk(1'b0, 5'h00, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 32'h8000_0180));
        CP0_IntPending = 1'b0;

        // Stall with a pending syscall, then reset in WAIT_RDR.
        EXE_Valid = 1'b1; EXE_PC = 32'h8000_1000; EXE_ExcSys = 1'b1;
        sb_q.push_back(mk(1'b0, 5'h08, 32'h8000_1000, 1'b0, 1'b0, 32'h0, 32'h8000_0180));
        tick();
        MEM_Stall = 1'b1;
        clr_exe();
        tick();
        chk("stall_no_we1", 32'(Exc_We), 32'd0);
        chk("stall_no_flush1", 32'(MEM_Flush), 32'd0);
        tick();
        chk("stall_no_we2", 32'(Exc_We), 32'd0);
        chk("stall_no_rdr2", 32'(Redirect_Valid), 32'd0);
        MEM_Stall = 1'b0;
        tick();
        chk("stall_release_we", 32'(Exc_We), 32'd1);
        tick();
        chk("pre_rst_rdr_valid", 32'(Redirect_Valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_rdr_valid", 32'(Redirect_Valid), 32'd0);
        chk("midrst_rdr_pc", Redirect_PC, 32'h0);
        chk("midrst_code", 32'(Exc_Code), 32'd0);
        chk("midrst_epc", Exc_EPC, 32'h0);
        chk("midrst_we", 32'(Exc_We), 32'd0);
        chk("midrst_flush", 32'(MEM_Flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Back in RUN after reset: break with BEV=1.
        CP0_StatusBEV = 1'b1;
        EXE_Valid = 1'b1; EXE_PC = 32'h8000_0200; EXE_ExcBp = 1'b1;
        exc_case("bp", mk(1'b0, 5'h09, 32'h8000_0200, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380));

        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
